radio_rx_decim_lanes: RTL
=========================

// Module: radio_rx_decim_lanes
// PURPOSE
//  Parametrised multi-lane I/Q receive decimator; sits after the per-lane DDC in the receive chain.
//  Each lane runs an integrate-and-dump decimator with a runtime-selectable rate R = 2^k.
//  Each output is rounded and saturated from IN_W to OUT_W.
//  I and Q of a lane share one AXI-stream handshake; lanes are fully independent.
// PARAMETERS
//  LANES       8   number of independent I/Q lanes
//  IN_W        16  input sample width (signed two's complement)
//  OUT_W       8   output sample width (signed), OUT_W <= IN_W
//  MAX_R_LOG2  3   largest supported log2 decimation rate (R up to 8)
// PORTS
//  clk_500m        in   1             single clock; all logic on its rising edge
//  reset           in   1             asynchronous assert, active-low; deassertion synchronised externally
//  cfg_rate_log2   in   3             k, with R = 2^k; values > MAX_R_LOG2 clamp to MAX_R_LOG2
//  s_axis_tvalid   in   LANES         per-lane input valid
//  s_axis_tready   out  LANES         per-lane input ready
//  s_axis_tlast    in   LANES         per-lane end of frame
//  s_axis_tdata_i  in   LANES*IN_W    lane l occupies bits [l*IN_W +: IN_W]
//  s_axis_tdata_q  in   LANES*IN_W    same packing as tdata_i
//  m_axis_tvalid   out  LANES         per-lane output valid
//  m_axis_tready   in   LANES         per-lane output ready
//  m_axis_tlast    out  LANES         end of frame, aligned with the flushing output
//  m_axis_tdata_i  out  LANES*OUT_W   lane l occupies bits [l*OUT_W +: OUT_W]
//  m_axis_tdata_q  out  LANES*OUT_W   same packing as tdata_i
//  sat_flag        out  LANES         sticky: set when any I/Q output was clipped; cleared only by reset
//  ovf_count       out  LANES*16      per-lane clip counter; present only with the macro (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0): cnt=0; acc_i=acc_q=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0;
//    s_axis_tready=0 while reset is asserted, 1 from the first edge after release; sat_flag=0; ovf_count=0.
//    Reset mid-frame discards the partial accumulation and any held output.
//  Per-lane states:
//    IDLE (cnt==0) -> ACCUM on an accepted beat with R>1 and tlast==0.
//    ACCUM -> DUMP on the R-th beat or on a tlast beat.
//    DUMP loads the output register: HOLD if m_axis_tready==0, otherwise back to IDLE.
//    HOLD -> IDLE once m_axis_tvalid && m_axis_tready.
//  Rate latch: k is sampled per lane on the accepted beat that finds cnt==0.
//    k stays constant until that lane's dump; mid-block changes of cfg_rate_log2 are ignored.
//  Handshake:
//    s_axis_tready[l] = !(m_axis_tvalid[l] && !m_axis_tready[l]).
//    A beat is accepted on s_axis_tvalid && s_axis_tready.
//    m_axis_tdata and m_axis_tlast stay stable while m_axis_tvalid && !m_axis_tready.
//  Accumulator: width AW = IN_W+MAX_R_LOG2+1, signed.
//    First beat of a block: acc = sign-extended x. Later beats: acc = acc + x.
//  Dump arithmetic: shift S = k + (IN_W-OUT_W).
//    r = (acc + (S>0 ? 1<<(S-1) : 0)) >>> S  (round half up, arithmetic shift).
//    Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; I and Q are processed identically.
//  Early tlast: dump immediately with the same S, so the partial block is scaled by 1/R, not 1/n.
//    m_axis_tlast=1 on that output; cnt returns to 0.
//  Latency: m_axis_tvalid asserts on the first edge after the dumping input beat is accepted.
//  Throughput: one output per R accepted inputs. With R=1 and m_axis_tready=1, one output per cycle.
//    A dump beat and the drain of the previous output in the same cycle is legal and loses nothing.
//  sat_flag[l] sets in the dump cycle when either I or Q clips.
// CONFIGURATION
//  RADIO_RX_DECIM_OVF_CNT_EN
//    Defined: ovf_count[l] increments by 1 per dump in which I or Q clipped (both clipping counts as 1).
//      The counter saturates at 0xFFFF and is cleared only by reset.
//    Undefined: ovf_count is driven to all zeros and no counter logic is built; sat_flag is unaffected.
// TESTING
//  T1 k=0, lane0 input I=0x1234, Q=0xEDCC -> one cycle later out I=0x12, Q=0xEE, tlast=0.
//  T2 k=1, lane3 inputs I=0x0100 then 0x0300 -> one output I=0x02; no output after the first beat.
//  T3 k=0, input I=0x7FF0 -> out I=0x7F, sat_flag[0]=1, ovf_count[0]=1 with the macro (0 without).
//  T4 k=3, m_axis_tready=0 held 10 cycles after a dump -> s_axis_tready=0, data stable.
//     On release, the held output transfers first and no input beat is lost.
//  T5 k=2, tlast on the 2nd beat with I=0x0400 each beat -> output I=0x02, tlast=1; next block starts at cnt=0.
//  T6 reset pulsed low mid-block (k=3, 5 beats in) -> all outputs 0.
//     After release, the next 8 beats produce exactly one output with no residue from the aborted block.

Source files
------------

// File: rtl/radio_rx_decim_lanes.sv
// ============================================================================
// Module      : radio_rx_decim_lanes
// Description : Multi-lane I/Q integrate-and-dump decimator (R = 2^k) with
//               round-half-up, saturation to OUT_W and per-lane AXI-stream.
//               Optional per-lane clip counter: RADIO_RX_DECIM_OVF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module radio_rx_decim_lanes #(
  parameter int LANES      = 8,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int MAX_R_LOG2 = 3
) (
  input  logic                   clk_500m,
  input  logic                   reset,
  input  logic [2:0]             cfg_rate_log2,
  input  logic [LANES-1:0]       s_axis_tvalid,
  output logic [LANES-1:0]       s_axis_tready,
  input  logic [LANES-1:0]       s_axis_tlast,
  input  logic [LANES*IN_W-1:0]  s_axis_tdata_i,
  input  logic [LANES*IN_W-1:0]  s_axis_tdata_q,
  output logic [LANES-1:0]       m_axis_tvalid,
  input  logic [LANES-1:0]       m_axis_tready,
  output logic [LANES-1:0]       m_axis_tlast,
  output logic [LANES*OUT_W-1:0] m_axis_tdata_i,
  output logic [LANES*OUT_W-1:0] m_axis_tdata_q,
  output logic [LANES-1:0]       sat_flag,
  output logic [LANES*16-1:0]    ovf_count
);

  localparam int AW = IN_W + MAX_R_LOG2 + 1;
  localparam int CW = MAX_R_LOG2 + 1;
  localparam int DS = IN_W - OUT_W;
  localparam logic signed [AW:0] SMAX = (AW+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [AW:0] SMIN = (AW+1)'(-(1 << (OUT_W-1)));

  // Returns {clipped, value}: round half up by 2^(k+DS), then saturate.
  function automatic logic [OUT_W:0] round_sat(input logic signed [AW-1:0] acc,
                                               input logic [2:0] k);
    logic signed [AW:0] wide;
    logic signed [AW:0] rnd;
    logic signed [AW:0] r;
    int s;
    s    = int'(k) + DS;
    wide = {acc[AW-1], acc};
    rnd  = '0;
    if (s > 0) rnd = (AW+1)'(1) << (s - 1);
    r = (wide + rnd) >>> s;
    if (r > SMAX)      round_sat = {1'b1, SMAX[OUT_W-1:0]};
    else if (r < SMIN) round_sat = {1'b1, SMIN[OUT_W-1:0]};
    else               round_sat = {1'b0, r[OUT_W-1:0]};
  endfunction

  logic       rdy_en_q;
  logic [2:0] k_cfg;

  assign k_cfg = (cfg_rate_log2 > 3'(MAX_R_LOG2)) ? 3'(MAX_R_LOG2) : cfg_rate_log2;

  // Holds tready low during reset and releases it on the first edge afterwards.
  always_ff @(posedge clk_500m or negedge reset) begin
    if (!reset) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CW-1:0]          cnt_q, cnt_d, last_cnt;
    logic [2:0]             k_q, k_d, k_eff;
    logic signed [AW-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [AW-1:0]   sx_i, sx_q, sum_i, sum_q;
    logic [OUT_W-1:0]       out_i_q, out_i_d, out_q_q, out_q_d;
    logic                   vld_q, vld_d, last_q, last_d, sat_q, sat_d;
    logic [OUT_W:0]         res_i, res_q;
    logic                   first, accept, dump, clip;
    logic [IN_W-1:0]        x_i, x_q;

    assign x_i    = s_axis_tdata_i[l*IN_W +: IN_W];
    assign x_q    = s_axis_tdata_q[l*IN_W +: IN_W];
    assign sx_i   = $signed({{(AW-IN_W){x_i[IN_W-1]}}, x_i});
    assign sx_q   = $signed({{(AW-IN_W){x_q[IN_W-1]}}, x_q});
    assign first  = (cnt_q == '0);
    assign k_eff  = first ? k_cfg : k_q;
    assign last_cnt = (CW'(1) << k_eff) - CW'(1);
    assign sum_i  = first ? sx_i : acc_i_q + sx_i;
    assign sum_q  = first ? sx_q : acc_q_q + sx_q;
    assign res_i  = round_sat(sum_i, k_eff);
    assign res_q  = round_sat(sum_q, k_eff);
    assign clip   = res_i[OUT_W] | res_q[OUT_W];
    assign accept = s_axis_tvalid[l] & s_axis_tready[l];
    assign dump   = accept & ((cnt_q == last_cnt) | s_axis_tlast[l]);

    always_comb begin
      cnt_d   = cnt_q;
      k_d     = k_q;
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      out_i_d = out_i_q;
      out_q_d = out_q_q;
      vld_d   = vld_q;
      last_d  = last_q;
      sat_d   = sat_q;
      if (vld_q && m_axis_tready[l]) vld_d = 1'b0;
      if (dump) begin
        cnt_d   = '0;
        out_i_d = res_i[OUT_W-1:0];
        out_q_d = res_q[OUT_W-1:0];
        vld_d   = 1'b1;
        last_d  = s_axis_tlast[l];
        sat_d   = sat_q | clip;
      end else if (accept) begin
        cnt_d   = cnt_q + CW'(1);
        k_d     = k_eff;
        acc_i_d = sum_i;
        acc_q_d = sum_q;
      end
    end

    always_ff @(posedge clk_500m or negedge reset) begin
      if (!reset) begin
        cnt_q   <= '0;
        k_q     <= '0;
        acc_i_q <= '0;
        acc_q_q <= '0;
        out_i_q <= '0;
        out_q_q <= '0;
        vld_q   <= 1'b0;
        last_q  <= 1'b0;
        sat_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        k_q     <= k_d;
        acc_i_q <= acc_i_d;
        acc_q_q <= acc_q_d;
        out_i_q <= out_i_d;
        out_q_q <= out_q_d;
        vld_q   <= vld_d;
        last_q  <= last_d;
        sat_q   <= sat_d;
      end
    end

    assign s_axis_tready[l]                 = rdy_en_q & ~(vld_q & ~m_axis_tready[l]);
    assign m_axis_tvalid[l]                 = vld_q;
    assign m_axis_tlast[l]                  = last_q;
    assign m_axis_tdata_i[l*OUT_W +: OUT_W] = out_i_q;
    assign m_axis_tdata_q[l*OUT_W +: OUT_W] = out_q_q;
    assign sat_flag[l]                      = sat_q;

`ifdef RADIO_RX_DECIM_OVF_CNT_EN
    logic [15:0] ovf_q;
    always_ff @(posedge clk_500m or negedge reset) begin
      if (!reset)                             ovf_q <= '0;
      else if (dump && clip && ovf_q != '1)   ovf_q <= ovf_q + 16'd1;
    end
    assign ovf_count[l*16 +: 16] = ovf_q;
`else
    assign ovf_count[l*16 +: 16] = 16'h0000;
`endif
  end

endmodule

`default_nettype wire
